cache_fill_arbiter: RTL and testbench
=====================================

// Module: cache_fill_arbiter
// PURPOSE
//  Shares the single multi-cycle main memory between the I-cache miss path (fetch side of the PC update logic)
//  and the D-cache miss/store path. Grants one requester, sequences a pipelined 8-word line fill (or one store
//  write), and steers returning words to the granted cache. Sits between both caches and the memory model.
// PARAMETERS
//  ADDR_W   16  byte address width
//  DATA_W   16  memory word width
//  WORDS    8   words per cache line (power of two; line = 2*WORDS bytes)
//  MEM_LAT  4   cycles from read issue (mem_en=1,mem_wr=0) to mem_data_valid for that word
// PORTS
//  clk             in   1       system clock, rising edge
//  rst             in   1       asynchronous, active-high reset
//  i_miss          in   1       I-cache line fill request (level, held until i_fill_done)
//  i_addr          in   ADDR_W  I-miss byte address
//  d_miss          in   1       D-cache line fill request (level, held until d_fill_done)
//  d_addr          in   ADDR_W  D-miss or store byte address
//  d_wr            in   1       D-side write-through store request (level, held until d_wr_ack)
//  d_wdata         in   DATA_W  store data
//  mem_en          out  1       memory access strobe
//  mem_wr          out  1       1=write, 0=read (valid with mem_en)
//  mem_addr        out  ADDR_W  memory byte address
//  mem_wdata       out  DATA_W  memory write data
//  mem_data_valid  in   1       read word returned this cycle
//  mem_rdata       in   DATA_W  returned word
//  fill_valid      out  1       fill word valid to cache selected by fill_tgt
//  fill_tgt        out  1       0=I-cache, 1=D-cache
//  fill_idx        out  log2(WORDS)  word index within line
//  fill_data       out  DATA_W  fill word (= mem_rdata, combinational pass-through)
//  i_fill_done     out  1       one-cycle pulse: I line complete
//  d_fill_done     out  1       one-cycle pulse: D line complete
//  d_wr_ack        out  1       one-cycle pulse: store issued to memory
//  busy            out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, all counters 0, last_d=0, every output 0. Reset mid-fill aborts; no done pulse.
//  States: IDLE -> WRITE | FILL; WRITE -> IDLE; FILL -> DONE; DONE -> IDLE.
//  Arbitration (IDLE only, requests sampled every IDLE cycle):
//   - d_wr wins over d_miss; D side wins over i_miss, EXCEPT when last_d=1 and i_miss=1 -> grant I.
//   - last_d <= 1 on any D grant, 0 on I grant. Guarantees I served after at most one D op.
//   - granted addr latched; base = addr with low log2(2*WORDS) bits cleared.
//  WRITE (1 cycle): mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, d_wr_ack=1; next IDLE.
//  FILL: issue_cnt 0..WORDS-1, one read per cycle: mem_en=1, mem_wr=0, mem_addr=base+2*issue_cnt.
//   mem_en=0 once issue_cnt reaches WORDS. recv_cnt increments on each mem_data_valid;
//   fill_valid=mem_data_valid, fill_idx=recv_cnt, fill_tgt=granted side.
//   Last word received (recv_cnt==WORDS-1 & valid) -> DONE. Fill of WORDS words spans WORDS+MEM_LAT-1 cycles.
//  DONE (1 cycle): pulse i_fill_done or d_fill_done per grant; no sampling; next IDLE.
//   Requester must drop its request the cycle after done; IDLE re-arbitrates.
//  mem_data_valid outside FILL is ignored (no fill_valid). Address adds wrap modulo 2^ADDR_W.
//  Outputs mem_*, fill_tgt, *_done, d_wr_ack are 0 in IDLE; requests changing mid-op do not alter grant.
// STRUCTURE
//  Package cache_arb_pkg: state enum {IDLE,WRITE,FILL,DONE}; TGT_I=1'b0, TGT_D=1'b1; LINE_OFF_W.
//  One sub-module: fill_counter (WORDS-range up counter, clear/inc/at_max), instanced for issue and recv.
// TESTING (bench memory model returns MEM_LAT=4 cycles after each read)
//  1. i_miss=1, i_addr=0x1236 -> reads 0x1230..0x123E cycles 1-8, fill_valid idx 0..7 cycles 4-11, fill_tgt=0, i_fill_done pulse cycle 12.
//  2. i_miss & d_miss both 1, last_d=0 -> D line filled first (fill_tgt=1), then I line; d_fill_done precedes i_fill_done.
//  3. d_wr=1, d_addr=0x0040, d_wdata=0xBEEF with d_miss=1 -> one cycle mem_wr=1 addr 0x0040 data 0xBEEF, d_wr_ack; then D fill.
//  4. Continuous d_miss plus i_miss held -> grants alternate D,I,D,I; I never waits more than one D op.
//  5. rst asserted at fill word 3 -> all outputs 0 immediately, busy=0, no done pulse; late mem_data_valid ignored.
//  6. d_addr=0xFFFA fill -> addresses 0xFFF0..0xFFFE, no wrap past line; busy high from grant through DONE.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache fill arbiter: FSM states,
// fill target encoding and line-offset helpers.
package cache_arb_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} arb_state_t;

  localparam logic TGT_I = 1'b0;
  localparam logic TGT_D = 1'b1;

  // Byte-offset width of the default 8-word line of 16-bit words.
  localparam int LINE_OFF_W = 4;

  function automatic int lineOffW(input int words);
    return $clog2(2 * words);
  endfunction

endpackage

// File: rtl/fill_counter.sv
// Saturating up counter over 0..WORDS-1, used to index reads issued and
// words received within one cache line.
module fill_counter #(
  parameter int WORDS = 8,
  parameter int CW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_inc,
  output logic [CW-1:0] o_count,
  output logic          o_at_max
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && !o_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count  = r_count;
  assign o_at_max = (r_count == CW'(WORDS - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates the shared main memory between I-cache fills and D-cache
// fills/stores, sequences pipelined line reads and steers returned words.
module cache_fill_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int WORDS   = 1 << (LINE_OFF_W - 1),
  parameter int MEM_LAT = 4,
  parameter int IDX_W   = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fill_valid,
  output logic              fill_tgt,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              busy
);

  localparam int OffW = lineOffW(WORDS);
  localparam logic [ADDR_W-1:0] OffMask = ADDR_W'((1 << OffW) - 1);

  arb_state_t        r_state;
  logic              r_lastD;
  logic              r_tgt;
  logic [ADDR_W-1:0] r_base;
  logic              r_memEn;
  logic              r_memWr;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic              r_iDone;
  logic              r_dDone;
  logic              r_wrAck;

  logic              w_dReq;
  logic              w_grantI;
  logic [ADDR_W-1:0] w_reqAddr;
  logic [ADDR_W-1:0] w_reqBase;
  logic              w_inFill;
  logic              w_recvLast;
  logic [ADDR_W-1:0] w_nextAddr;
  logic [IDX_W-1:0]  w_issueCnt;
  logic [IDX_W-1:0]  w_recvCnt;
  logic              w_issueMax;
  logic              w_recvMax;

  // I wins only if D is idle, or D was served last (bounds I wait to one D op).
  assign w_dReq     = d_wr | d_miss;
  assign w_grantI   = i_miss & (r_lastD | ~w_dReq);
  assign w_reqAddr  = w_grantI ? i_addr : d_addr;
  assign w_reqBase  = w_reqAddr & ~OffMask;
  assign w_inFill   = (r_state == FILL);
  assign w_recvLast = w_inFill & mem_data_valid & w_recvMax;
  assign w_nextAddr = r_base + ADDR_W'((32'(w_issueCnt) + 32'd1) << 1);

  fill_counter #(.WORDS(WORDS)) u_issueCnt (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (!w_inFill),
    .i_inc    (w_inFill),
    .o_count  (w_issueCnt),
    .o_at_max (w_issueMax)
  );

  fill_counter #(.WORDS(WORDS)) u_recvCnt (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (!w_inFill),
    .i_inc    (w_inFill & mem_data_valid),
    .o_count  (w_recvCnt),
    .o_at_max (w_recvMax)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lastD    <= 1'b0;
      r_tgt      <= TGT_I;
      r_base     <= '0;
      r_memEn    <= 1'b0;
      r_memWr    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_iDone    <= 1'b0;
      r_dDone    <= 1'b0;
      r_wrAck    <= 1'b0;
    end else begin
      r_iDone <= 1'b0;
      r_dDone <= 1'b0;
      r_wrAck <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_miss || w_dReq) begin
            r_base  <= w_reqBase;
            r_memEn <= 1'b1;
            if (w_grantI) begin
              r_state   <= FILL;
              r_tgt     <= TGT_I;
              r_lastD   <= 1'b0;
              r_memWr   <= 1'b0;
              r_memAddr <= w_reqBase;
            end else if (d_wr) begin
              r_state    <= WRITE;
              r_tgt      <= TGT_D;
              r_lastD    <= 1'b1;
              r_memWr    <= 1'b1;
              r_memAddr  <= d_addr;
              r_memWdata <= d_wdata;
              r_wrAck    <= 1'b1;
            end else begin
              r_state   <= FILL;
              r_tgt     <= TGT_D;
              r_lastD   <= 1'b1;
              r_memWr   <= 1'b0;
              r_memAddr <= w_reqBase;
            end
          end
        end
        WRITE: begin
          r_state    <= IDLE;
          r_tgt      <= TGT_I;
          r_memEn    <= 1'b0;
          r_memWr    <= 1'b0;
          r_memAddr  <= '0;
          r_memWdata <= '0;
        end
        FILL: begin
          if (w_issueMax) begin
            r_memEn   <= 1'b0;
            r_memAddr <= '0;
          end else begin
            r_memAddr <= w_nextAddr;
          end
          if (w_recvLast) begin
            r_state <= DONE;
            r_iDone <= (r_tgt == TGT_I);
            r_dDone <= (r_tgt == TGT_D);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_tgt   <= TGT_I;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_en      = r_memEn;
  assign mem_wr      = r_memWr;
  assign mem_addr    = r_memAddr;
  assign mem_wdata   = r_memWdata;
  assign fill_valid  = w_inFill & mem_data_valid;
  assign fill_tgt    = r_tgt;
  assign fill_idx    = w_recvCnt;
  assign fill_data   = mem_rdata;
  assign i_fill_done = r_iDone;
  assign d_fill_done = r_dDone;
  assign d_wr_ack    = r_wrAck;
  assign busy        = (r_state != IDLE);

  // Memory contract: first word of a line returns MEM_LAT-1 cycles after fill entry.
  assert property (@(posedge clk) disable iff (rst)
    (r_state == FILL && $past(r_state) == IDLE) |-> ##(MEM_LAT - 1) mem_data_valid);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Randomized bench for cache_fill_arbiter: a transaction planner predicts the
// per-cycle memory, fill and handshake activity for each batch of requests.
module tb_cache_fill_arbiter;

   localparam int HOR = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_miss, d_miss, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic        mem_en, mem_wr, mem_data_valid;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        fill_valid, fill_tgt;
   logic [2:0]  fill_idx;
   logic [15:0] fill_data;
   logic        i_fill_done, d_fill_done, d_wr_ack, busy;

   int total = 0;
   int bad   = 0;
   int curScn = 0;
   int curCyc = 0;

   always #5 clk = ~clk;

   cache_fill_arbiter #(
      .ADDR_W(16), .DATA_W(16), .WORDS(8), .MEM_LAT(4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_miss         (i_miss),
      .i_addr         (i_addr),
      .d_miss         (d_miss),
      .d_addr         (d_addr),
      .d_wr           (d_wr),
      .d_wdata        (d_wdata),
      .mem_en         (mem_en),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_data_valid (mem_data_valid),
      .mem_rdata      (mem_rdata),
      .fill_valid     (fill_valid),
      .fill_tgt       (fill_tgt),
      .fill_idx       (fill_idx),
      .fill_data      (fill_data),
      .i_fill_done    (i_fill_done),
      .d_fill_done    (d_fill_done),
      .d_wr_ack       (d_wr_ack),
      .busy           (busy)
   );

   // Memory model: a read seen in cycle c returns its word in cycle c+3.
   logic [15:0] salt = 16'h5A3C;
   logic [2:0]  pv = 3'b000;
   logic [15:0] pa0, pa1, pa2;

   function automatic logic [15:0] memWord(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ salt;
   endfunction

   always @(posedge clk) begin
      pv  <= {pv[1:0], mem_en & ~mem_wr};
      pa0 <= mem_addr;
      pa1 <= pa0;
      pa2 <= pa1;
   end

   assign mem_data_valid = pv[2];
   assign mem_rdata      = pv[2] ? memWord(pa2) : 16'h0000;

   // Operation lists for a batch and the planner's expected timeline.
   int          nI, nD;
   logic [15:0] opIAddr [8];
   int          opDKind [8];
   logic [15:0] opDAddr [8];
   logic [15:0] opDData [8];
   bit          mLastD;

   logic        eEn [HOR], eWr [HOR], eFv [HOR], eTgt [HOR];
   logic        eIDone [HOR], eDDone [HOR], eAck [HOR], eBusy [HOR];
   logic [15:0] eAddr [HOR], eWdata [HOR], eData [HOR];
   logic [2:0]  eIdx [HOR];
   logic        sIMiss [HOR], sDMiss [HOR], sDWr [HOR];
   logic [15:0] sIAddr [HOR], sDAddr [HOR], sDWdata [HOR];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s scn=%0d cyc=%0d got=0x%0h exp=0x%0h", tag, curScn, curCyc, got, exp);
      end
   endtask

   task automatic addFill(input int g, input logic [15:0] base, input logic tgt);
      for (int k = 0; k < 8; k++) begin
         eEn[g + 1 + k]   = 1'b1;
         eAddr[g + 1 + k] = base + 16'(2 * k);
         eFv[g + 4 + k]   = 1'b1;
         eIdx[g + 4 + k]  = 3'(k);
         eData[g + 4 + k] = memWord(base + 16'(2 * k));
         eTgt[g + 4 + k]  = tgt;
      end
      for (int c = g + 1; c <= g + 12; c++) eBusy[c] = 1'b1;
   endtask

   // Plans grants from the arbitration rules; requesters drop the cycle after done/ack.
   task automatic buildExpected(output int len);
      int t, iIdx, dIdx, iAvail, dAvail;
      bit dWrLeft, iReq, dReq;
      for (int c = 0; c < HOR; c++) begin
         eEn[c] = 0; eWr[c] = 0; eFv[c] = 0; eTgt[c] = 0;
         eIDone[c] = 0; eDDone[c] = 0; eAck[c] = 0; eBusy[c] = 0;
         eAddr[c] = 0; eWdata[c] = 0; eData[c] = 0; eIdx[c] = 0;
         sIMiss[c] = 0; sDMiss[c] = 0; sDWr[c] = 0;
         sIAddr[c] = 16'($urandom); sDAddr[c] = 16'($urandom); sDWdata[c] = 16'($urandom);
      end
      t = 0; iIdx = 0; dIdx = 0; iAvail = 0; dAvail = 0;
      dWrLeft = (nD > 0) && (opDKind[0] != 0);
      while (iIdx < nI || dIdx < nD) begin
         iReq = (iIdx < nI) && (t >= iAvail);
         dReq = (dIdx < nD) && (t >= dAvail);
         if (!iReq && !dReq) begin
            t++;
         end else if (iReq && (mLastD || !dReq)) begin
            for (int c = iAvail; c <= t + 12; c++) begin
               sIMiss[c] = 1'b1;
               sIAddr[c] = opIAddr[iIdx];
            end
            addFill(t, opIAddr[iIdx] & 16'hFFF0, 1'b0);
            eIDone[t + 12] = 1'b1;
            mLastD = 1'b0;
            iIdx++;
            iAvail = t + 14;
            t = t + 13;
         end else if (dWrLeft) begin
            for (int c = dAvail; c <= t + 1; c++) begin
               sDWr[c]    = 1'b1;
               sDAddr[c]  = opDAddr[dIdx];
               sDWdata[c] = opDData[dIdx];
            end
            eBusy[t + 1] = 1'b1; eEn[t + 1] = 1'b1; eWr[t + 1] = 1'b1;
            eAddr[t + 1] = opDAddr[dIdx]; eWdata[t + 1] = opDData[dIdx];
            eAck[t + 1] = 1'b1;
            mLastD = 1'b1;
            dWrLeft = 1'b0;
            if (opDKind[dIdx] == 1) begin
               dIdx++;
               dAvail = t + 3;
               dWrLeft = (dIdx < nD) && (opDKind[dIdx] != 0);
            end
            t = t + 2;
         end else begin
            for (int c = dAvail; c <= t + 12; c++) begin
               sDMiss[c] = 1'b1;
               sDAddr[c] = opDAddr[dIdx];
            end
            addFill(t, opDAddr[dIdx] & 16'hFFF0, 1'b1);
            eDDone[t + 12] = 1'b1;
            mLastD = 1'b1;
            dIdx++;
            dAvail = t + 14;
            dWrLeft = (dIdx < nD) && (opDKind[dIdx] != 0);
            t = t + 13;
         end
      end
      len = t + 4;
   endtask

   task automatic checkCycle(input int c);
      curCyc = c;
      checkOutput("busy", 32'(busy), 32'(eBusy[c]));
      checkOutput("mem_en", 32'(mem_en), 32'(eEn[c]));
      if (eEn[c]) begin
         checkOutput("mem_wr", 32'(mem_wr), 32'(eWr[c]));
         checkOutput("mem_addr", 32'(mem_addr), 32'(eAddr[c]));
         if (eWr[c]) checkOutput("mem_wdata", 32'(mem_wdata), 32'(eWdata[c]));
      end
      if (!eBusy[c]) begin
         checkOutput("idle_mem_wr", 32'(mem_wr), 32'd0);
         checkOutput("idle_mem_addr", 32'(mem_addr), 32'd0);
         checkOutput("idle_mem_wdata", 32'(mem_wdata), 32'd0);
         checkOutput("idle_fill_tgt", 32'(fill_tgt), 32'd0);
      end
      checkOutput("fill_valid", 32'(fill_valid), 32'(eFv[c]));
      if (eFv[c]) begin
         checkOutput("fill_tgt", 32'(fill_tgt), 32'(eTgt[c]));
         checkOutput("fill_idx", 32'(fill_idx), 32'(eIdx[c]));
         checkOutput("fill_data", 32'(fill_data), 32'(eData[c]));
      end
      checkOutput("i_fill_done", 32'(i_fill_done), 32'(eIDone[c]));
      checkOutput("d_fill_done", 32'(d_fill_done), 32'(eDDone[c]));
      checkOutput("d_wr_ack", 32'(d_wr_ack), 32'(eAck[c]));
   endtask

   task automatic applyStimulus();
      int len;
      curScn++;
      buildExpected(len);
      for (int c = 0; c < len; c++) begin
         @(posedge clk);
         #1;
         i_miss = sIMiss[c]; i_addr = sIAddr[c];
         d_miss = sDMiss[c]; d_wr = sDWr[c];
         d_addr = sDAddr[c]; d_wdata = sDWdata[c];
         @(negedge clk);
         checkCycle(c);
      end
      i_miss = 0; d_miss = 0; d_wr = 0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_mem_en"}, 32'(mem_en), 32'd0);
      checkOutput({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
      checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      checkOutput({tag, "_fill_valid"}, 32'(fill_valid), 32'd0);
      checkOutput({tag, "_fill_tgt"}, 32'(fill_tgt), 32'd0);
      checkOutput({tag, "_fill_idx"}, 32'(fill_idx), 32'd0);
      checkOutput({tag, "_done"}, 32'({i_fill_done, d_fill_done, d_wr_ack}), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   // Reset lands while word 3 of an I line is being returned.
   task automatic resetMidFill();
      curScn++;
      @(posedge clk);
      #1;
      i_miss = 1; i_addr = 16'h2468; d_miss = 0; d_wr = 0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      curCyc = 7;
      checkOutput("pre_rst_valid", 32'(fill_valid), 32'd1);
      checkOutput("pre_rst_idx", 32'(fill_idx), 32'd3);
      rst = 1;
      #1;
      checkAllZero("mid_rst");
      @(posedge clk);
      #1;
      i_miss = 0;
      @(posedge clk);
      #1;
      rst = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         curCyc = 100 + c;
         checkAllZero("post_rst");
      end
      mLastD = 0;
   endtask

   initial begin
      rst = 0; i_miss = 0; d_miss = 0; d_wr = 0;
      i_addr = 0; d_addr = 0; d_wdata = 0;
      #1 rst = 1;
      #1;
      checkAllZero("reset");
      repeat (2) @(negedge clk);
      checkAllZero("reset_hold");
      @(posedge clk);
      #1 rst = 0;
      mLastD = 0;

      $display("[TB] I line fill at 0x1236");
      nI = 1; nD = 0; opIAddr[0] = 16'h1236;
      applyStimulus();

      $display("[TB] simultaneous I and D misses");
      nI = 1; nD = 1; opIAddr[0] = 16'h0456; opDKind[0] = 0; opDAddr[0] = 16'h2222;
      applyStimulus();

      $display("[TB] store plus D miss at 0x0040");
      nI = 0; nD = 1; opDKind[0] = 2; opDAddr[0] = 16'h0040; opDData[0] = 16'hBEEF;
      applyStimulus();

      $display("[TB] D fill at top of address space");
      nI = 0; nD = 1; opDKind[0] = 0; opDAddr[0] = 16'hFFFA;
      applyStimulus();

      $display("[TB] continuous D and I traffic");
      nI = 3; nD = 3;
      for (int k = 0; k < 3; k++) begin
         opIAddr[k] = 16'h3000 + 16'(k * 16'h0110);
         opDKind[k] = 0;
         opDAddr[k] = 16'h8000 + 16'(k * 16'h0230);
      end
      applyStimulus();

      $display("[TB] randomized batches");
      for (int s = 0; s < 24; s++) begin
         salt = 16'($urandom);
         nI = $urandom_range(0, 3);
         nD = $urandom_range(0, 3);
         if (nI == 0 && nD == 0) nI = 1;
         for (int k = 0; k < 4; k++) begin
            opIAddr[k] = 16'($urandom);
            opDKind[k] = $urandom_range(0, 2);
            opDAddr[k] = 16'($urandom);
            opDData[k] = 16'($urandom);
         end
         applyStimulus();
      end

      $display("[TB] reset during fill");
      resetMidFill();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
